// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-cycle memory requests, DEPTH-entry buffer with
// empty-buffer bypass, redirect flush and halt-on-opcode.
module fetch_unit #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned DEPTH    = 2,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_en,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [7:0]  out_pc,
   output logic        halted
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [7:0]    fetch_pc_q, fetch_pc_d;
   logic [7:0]    rsp_pc_q, rsp_pc_d;
   logic          inflight_q, inflight_d;
   logic          halted_q, halted_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   buf_instr_q [DEPTH];
   logic [7:0]    buf_pc_q [DEPTH];

   logic          rsp_vld, buf_empty, pop, buf_pop, push, halt_hit, issue;
   logic [15:0]   head_instr;
   logic [7:0]    head_pc;
   logic [CW:0]   occ_after_pop;

   // A response arriving into an empty buffer is presented directly, giving one-cycle latency.
   always_comb begin
      rsp_vld    = inflight_q & ~halted_q;
      buf_empty  = (count_q == '0);
      head_instr = buf_empty ? imem_rdata : buf_instr_q[head_q];
      head_pc    = buf_empty ? rsp_pc_q : buf_pc_q[head_q];
      out_valid  = ~buf_empty | rsp_vld;
      out_instr  = out_valid ? head_instr : 16'h0000;
      out_pc     = out_valid ? head_pc : 8'h00;
      halted     = halted_q;

      pop      = out_valid & out_ready;
      buf_pop  = pop & ~buf_empty;
      push     = rsp_vld & ~(buf_empty & pop) & ~redirect;
      halt_hit = rsp_vld & ~redirect & (imem_rdata[15:12] == HALT_OP);

      occ_after_pop = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue     = ~rst & ~halted_q & ~redirect & (occ_after_pop < DEPTH_W);
      imem_en   = issue;
      imem_addr = fetch_pc_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = issue ? fetch_pc_q : rsp_pc_q;
      inflight_d = issue;
      halted_d   = halted_q | halt_hit;
      head_d     = head_q + AW'(buf_pop);
      tail_d     = tail_q + AW'(push);
      count_d    = count_q + CW'(push) - CW'(buf_pop);

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         halted_d   = 1'b0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else if (halt_hit) begin
         // Park just past the halt so a later look at fetch state is meaningful.
         fetch_pc_d = rsp_pc_q + 8'd1;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= 8'h00;
         inflight_q <= 1'b0;
         halted_q   <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         halted_q   <= halted_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[tail_q] <= imem_rdata;
         buf_pc_q[tail_q]    <= rsp_pc_q;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a stream-level model.
module tb_fetch_unit;
   localparam int DEPTH = 4;
   localparam logic [7:0] RPC = 8'h00;

   logic        clk;
   logic        rst;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;
   logic        halted;

   logic [15:0] mem [256];

   int total = 0;
   int bad   = 0;

   // Stream-level model: the delivered sequence restarts at the reset/redirect PC
   // and runs consecutively up to and including the first halt instruction.
   int         issued, delivered;
   logic [7:0] m_pc, m_req;
   bit         done, hm, vis_halt;

   fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial imem_rdata = 16'h0000;
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
      else         imem_rdata <= 16'($urandom);
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input logic [7:0] pc);
      m_pc = pc; m_req = pc;
      issued = 0; delivered = 0;
      done = 0; hm = 0; vis_halt = 0;
   endtask

   task automatic model();
      bit ev, ei, pop, nvis, nhm;
      int pend;
      if (rst) begin
         chk("rst_imem_en", imem_en, 0);
         chk("rst_imem_addr", imem_addr, RPC);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_instr", out_instr, 0);
         chk("rst_out_pc", out_pc, 0);
         chk("rst_halted", halted, 0);
         model_reset(RPC);
         return;
      end
      ev   = !done && (issued - delivered) > 0;
      pend = issued - delivered - ((ev && out_ready) ? 1 : 0);
      ei   = !redirect && !hm && (pend < DEPTH);
      chk("halted", halted, hm);
      chk("out_valid", out_valid, ev);
      if (ev) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_instr", out_instr, mem[m_pc]);
      end
      chk("imem_en", imem_en, ei);
      if (ei) chk("imem_addr", imem_addr, m_req);

      pop  = ev && out_ready;
      nvis = ei && (mem[m_req][15:12] == 4'hF);
      nhm  = !redirect && (hm || vis_halt);
      if (pop) begin
         delivered++;
         if (mem[m_pc][15:12] == 4'hF) done = 1;
         m_pc++;
      end
      if (ei) begin
         issued++;
         m_req++;
      end
      vis_halt = nvis;
      hm       = nhm;
      if (redirect) model_reset(redirect_pc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      model();
   endtask

   initial begin
      int nreq;
      logic [7:0] seq [4];
      seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      model_reset(RPC);
      rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
      #1 rst = 1'b1;
      #1;
      chk("init_imem_en", imem_en, 0);
      chk("init_out_valid", out_valid, 0);
      chk("init_halted", halted, 0);

      // Reset release and full-rate streaming.
      step(); mid();
      step(); mid();
      step(); rst = 1'b0; mid();
      chk("a_s0_en", imem_en, 1);
      chk("a_s0_addr", imem_addr, 8'h00);
      chk("a_s0_valid", out_valid, 0);
      step(); mid();
      chk("a_s1_valid", out_valid, 1);
      chk("a_s1_pc", out_pc, 8'h00);
      chk("a_s1_instr", out_instr, 16'h1000);
      chk("a_s1_addr", imem_addr, 8'h01);
      step(); mid();
      chk("a_s2_pc", out_pc, 8'h01);
      chk("a_s2_instr", out_instr, 16'h1001);

      // Backpressure right after the first valid instruction.
      step(); rst = 1'b1; #1;
      chk("b_rst_valid", out_valid, 0);
      mid();
      step(); mid();
      step(); rst = 1'b0; mid();
      nreq = 0;
      if (imem_en) nreq++;
      step(); out_ready = 1'b0; mid();
      if (imem_en) nreq++;
      chk("b_first_pc", out_pc, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(); mid();
         if (imem_en) nreq++;
      end
      chk("b_nreq", nreq, DEPTH);
      chk("b_stall_en", imem_en, 0);
      chk("b_stall_pc", out_pc, 8'h00);
      chk("b_stall_valid", out_valid, 1);
      step(); out_ready = 1'b1; mid();
      chk("b_rel_pc0", out_pc, 8'h00);
      step(); mid();
      chk("b_rel_pc1", out_pc, 8'h01);
      step(); mid();
      chk("b_rel_pc2", out_pc, 8'h02);

      // Redirect while the buffer holds entries.
      step(); out_ready = 1'b0; mid();
      step(); mid();
      step(); redirect = 1'b1; redirect_pc = 8'h40; mid();
      chk("c_redir_en", imem_en, 0);
      step(); redirect = 1'b0; out_ready = 1'b1; mid();
      chk("c_flush_valid", out_valid, 0);
      chk("c_new_en", imem_en, 1);
      chk("c_new_addr", imem_addr, 8'h40);
      step(); mid();
      chk("c_new_pc", out_pc, 8'h40);
      chk("c_new_instr", out_instr, 16'h1040);

      // Halt opcode at address 5, then restart by redirect.
      step(); rst = 1'b1; mem[5] = 16'hF000; mid();
      step(); mid();
      step(); rst = 1'b0; mid();
      for (int i = 1; i <= 6; i++) begin
         step(); mid();
      end
      chk("d_halt_pc", out_pc, 8'h05);
      chk("d_halt_instr", out_instr, 16'hF000);
      step(); mid();
      chk("d_halted", halted, 1);
      chk("d_halt_valid", out_valid, 0);
      chk("d_halt_en", imem_en, 0);
      step(); mid();
      chk("d_halt_en2", imem_en, 0);
      step(); redirect = 1'b1; redirect_pc = 8'h00; mid();
      step(); redirect = 1'b0; mid();
      chk("d_restart_halted", halted, 0);
      chk("d_restart_en", imem_en, 1);
      chk("d_restart_addr", imem_addr, 8'h00);
      step(); mid();
      chk("d_restart_pc", out_pc, 8'h00);
      for (int i = 0; i < 8; i++) begin
         step(); mid();
      end
      chk("d_halted_again", halted, 1);
      mem[5] = 16'h1005;

      // PC wrap across 8'hFF.
      step(); redirect = 1'b1; redirect_pc = 8'hFE; mid();
      step(); redirect = 1'b0; mid();
      chk("e_en", imem_en, 1);
      chk("e_addr", imem_addr, 8'hFE);
      for (int i = 0; i < 4; i++) begin
         step(); mid();
         chk("e_wrap_pc", out_pc, seq[i]);
      end

      // Reset pulse with the buffer full.
      step(); out_ready = 1'b0; mid();
      for (int i = 0; i < 6; i++) begin
         step(); mid();
      end
      chk("f_full_valid", out_valid, 1);
      step(); rst = 1'b1; #1;
      chk("f_rst_valid", out_valid, 0);
      chk("f_rst_halted", halted, 0);
      chk("f_rst_instr", out_instr, 0);
      mid();
      step(); mid();
      step(); rst = 1'b0; out_ready = 1'b1; mid();
      chk("f_restart_en", imem_en, 1);
      chk("f_restart_addr", imem_addr, RPC);

      // Randomized traffic with halts, redirects and reset pulses.
      step(); rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i][15:12] == 4'hF && $urandom_range(0, 2) != 0) mem[i][15:12] = 4'h7;
      end
      mid();
      step(); rst = 1'b0; mid();
      for (int c = 0; c < 4000; c++) begin
         step();
         out_ready   = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 31) == 0);
         redirect_pc = 8'($urandom);
         rst         = ($urandom_range(0, 199) == 0);
         mid();
      end
      step(); rst = 1'b0; redirect = 1'b0; mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
